// File: rtl/trigger_output_shaper_if.sv
// Signal bundle between the calibration FSM side and the trigger output shaper.
// A trigger request is a level from the calibration FSM; the shaper acts on its
// 0->1 transition only, so there is no ready/back-pressure path: a request that
// arrives while the shaper cannot take it is counted as dropped, never stalled.
interface trigger_output_shaper_if #(
  parameter int DELAY_W = 24,
  parameter int CNT_W   = 16
);
  logic               trigger_request;
  logic               detector_ready;
  logic               arm;
  logic [DELAY_W-1:0] delay_cycles;
  logic               clear_counts;
  logic               trigger_out;
  logic               busy;
  logic [1:0]         shaper_state;
  logic [CNT_W-1:0]   issued_count;
  logic [CNT_W-1:0]   dropped_count;

  modport master (
    output trigger_request, detector_ready, arm, delay_cycles, clear_counts,
    input  trigger_out, busy, shaper_state, issued_count, dropped_count
  );

  modport slave (
    input  trigger_request, detector_ready, arm, delay_cycles, clear_counts,
    output trigger_out, busy, shaper_state, issued_count, dropped_count
  );
endinterface

// File: rtl/trigger_output_shaper.sv
// Turns each rising edge of the calibration FSM's trigger request into one
// delayed, fixed-width trigger pulse, with a detector-ready interlock, a
// post-pulse holdoff and saturating issued/dropped counters.
module trigger_output_shaper #(
  parameter int DELAY_W        = 24,
  parameter int PULSE_CYCLES   = 2000,
  parameter int HOLDOFF_CYCLES = 20000,
  parameter int CNT_W          = 16
) (
  input  logic clock,
  input  logic reset_signal,
  trigger_output_shaper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  // One shared down-counter serves delay, pulse width and holdoff.
  localparam int PW      = $clog2(PULSE_CYCLES + 1);
  localparam int HW      = $clog2(HOLDOFF_CYCLES + 1);
  localparam int W1      = (DELAY_W > PW) ? DELAY_W : PW;
  localparam int TIMER_W = (W1 > HW) ? W1 : HW;

  localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD  =
    (HOLDOFF_CYCLES > 0) ? TIMER_W'(HOLDOFF_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               trig_q, trig_d;
  logic               req_q;
  logic               rdy_meta_q, rdy_s_q;
  logic [CNT_W-1:0]   issued_q, dropped_q;
  logic               issue_inc, drop_inc;
  logic               req_edge;

  // Request history and detector_ready 2-FF synchronizer. req_q resets high so
  // a request held across reset release is not taken as a fresh edge.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      req_q      <= 1'b1;
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
    end else begin
      req_q      <= bus.trigger_request;
      rdy_meta_q <= bus.detector_ready;
      rdy_s_q    <= rdy_meta_q;
    end
  end

  assign req_edge = bus.trigger_request & ~req_q;

  // State register together with the shared timer and the registered pulse.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
    end
  end

  // Next-state logic; an armed request edge that cannot be served is dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    trig_d    = trig_q;
    issue_inc = 1'b0;
    drop_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_edge && bus.arm) begin
          if (rdy_s_q) begin
            state_d = DELAY;
            cnt_d   = TIMER_W'(bus.delay_cycles);
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      DELAY: begin
        drop_inc = req_edge & bus.arm;
        if (cnt_q == '0) begin
          state_d = PULSE;
          trig_d  = 1'b1;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        drop_inc = req_edge & bus.arm;
        if (cnt_q == '0) begin
          trig_d    = 1'b0;
          issue_inc = 1'b1;
          if (HOLDOFF_CYCLES > 0) begin
            state_d = HOLDOFF;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLDOFF: begin
        drop_inc = req_edge & bus.arm;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating readout counters; clear wins over a same-cycle increment.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else if (bus.clear_counts) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (issue_inc && issued_q != CNT_MAX) issued_q <= issued_q + 1'b1;
      if (drop_inc && dropped_q != CNT_MAX) dropped_q <= dropped_q + 1'b1;
    end
  end

  // Outputs, all derived directly from registers.
  always_comb begin
    bus.trigger_out   = trig_q;
    bus.busy          = (state_q != IDLE);
    bus.shaper_state  = state_q;
    bus.issued_count  = issued_q;
    bus.dropped_count = dropped_q;
  end

endmodule

// File: tb/tb_trigger_output_shaper.sv
// Directed bench for trigger_output_shaper with shortened pulse/holdoff and a
// narrow counter so saturation is reachable in a short run.
module tb_trigger_output_shaper;

  localparam int DELAY_W        = 24;
  localparam int PULSE_CYCLES   = 20;
  localparam int HOLDOFF_CYCLES = 200;
  localparam int CNT_W          = 4;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset_signal = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_issued = 0;
  int   exp_dropped = 0;
  logic abort_pulse = 1'b0;

  // Expected rise cycles of trigger_out, pushed when a request is driven.
  logic [31:0] exp_q[$];

  trigger_output_shaper_if #(.DELAY_W(DELAY_W), .CNT_W(CNT_W)) bus_if ();

  trigger_output_shaper #(
    .DELAY_W(DELAY_W),
    .PULSE_CYCLES(PULSE_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset_signal(reset_signal),
    .bus(bus_if.slave)
  );

  // Clock and edge counter: after tick(), cyc is the number of the last edge.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // One-cycle request pulse; its edge is seen at the next clock edge.
  task automatic pulse_req();
    bus_if.trigger_request = 1'b1;
    tick();
    bus_if.trigger_request = 1'b0;
  endtask

  // Accepted request with delay d; returns acceptance edge k. Delay input is
  // scrambled afterwards since it must have been latched at acceptance.
  task automatic fire(input int d, output int k);
    bus_if.delay_cycles = DELAY_W'(d);
    exp_q.push_back(32'(cyc + d + 2));
    pulse_req();
    k = cyc;
    bus_if.delay_cycles = DELAY_W'($urandom_range(0, 500));
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus_if.busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_issued"}, 32'(bus_if.issued_count), 32'(exp_issued));
    check({tag, "_dropped"}, 32'(bus_if.dropped_count), 32'(exp_dropped));
  endtask

  // Pulse monitor: every rise must match the head of the expected queue and
  // every complete pulse must last exactly PULSE_CYCLES clocks.
  logic trig_prev = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clock) begin
    if (bus_if.trigger_out === 1'b1 && !trig_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_pulse: rise at %0d, none expected", cyc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        assert (32'(cyc) === e) else begin
          errors++;
          $error("FAIL rise_cycle: got %0d expected %0d", cyc, e);
        end
      end
      rise_cyc = cyc;
    end
    if (bus_if.trigger_out !== 1'b1 && trig_prev && !abort_pulse) begin
      checks++;
      assert (cyc - rise_cyc === PULSE_CYCLES) else begin
        errors++;
        $error("FAIL pulse_width: got %0d expected %0d", cyc - rise_cyc, PULSE_CYCLES);
      end
    end
    trig_prev = (bus_if.trigger_out === 1'b1);
  end

  initial begin
    int k;
    int d;
    bus_if.trigger_request = 1'b1;
    bus_if.detector_ready  = 1'b1;
    bus_if.arm             = 1'b1;
    bus_if.delay_cycles    = '0;
    bus_if.clear_counts    = 1'b0;

    // Reset released with the request already high: not an edge.
    repeat (3) tick();
    check("rst_trig", 32'(bus_if.trigger_out), 32'd0);
    check("rst_state", 32'(bus_if.shaper_state), 32'd0);
    reset_signal = 1'b0;
    repeat (10) tick();
    check("held_req_busy", 32'(bus_if.busy), 32'd0);
    check("held_req_state", 32'(bus_if.shaper_state), 32'd0);
    check_counts("held_req");
    bus_if.trigger_request = 1'b0;
    tick();

    // Delay 100: rise at k+101, fall at k+101+P, idle at k+101+P+H.
    d = 100;
    fire(d, k);
    check("accept_state", 32'(bus_if.shaper_state), 32'd1);
    check("accept_busy", 32'(bus_if.busy), 32'd1);
    wait_until(k + d);
    check("delay_last_trig", 32'(bus_if.trigger_out), 32'd0);
    tick();
    check("pulse_first_trig", 32'(bus_if.trigger_out), 32'd1);
    check("pulse_state", 32'(bus_if.shaper_state), 32'd2);
    wait_until(k + d + PULSE_CYCLES);
    check("pulse_last_trig", 32'(bus_if.trigger_out), 32'd1);
    tick();
    exp_issued = sat_inc(exp_issued);
    check("fall_trig", 32'(bus_if.trigger_out), 32'd0);
    check("holdoff_state", 32'(bus_if.shaper_state), 32'd3);
    check_counts("first_pulse");
    wait_until(k + d + PULSE_CYCLES + HOLDOFF_CYCLES);
    check("holdoff_last_busy", 32'(bus_if.busy), 32'd1);
    tick();
    check("idle_busy", 32'(bus_if.busy), 32'd0);
    check("idle_state", 32'(bus_if.shaper_state), 32'd0);

    // Accepted at the edge right after IDLE entry; delay 0 rises at k+1.
    // A second edge inside PULSE and one inside HOLDOFF are both dropped.
    fire(0, k);
    wait_until(k + 1 + 10);
    pulse_req();
    exp_dropped = sat_inc(exp_dropped);
    check("drop_in_pulse_state", 32'(bus_if.shaper_state), 32'd2);
    wait_until(k + 1 + PULSE_CYCLES + 5);
    exp_issued = sat_inc(exp_issued);
    pulse_req();
    exp_dropped = sat_inc(exp_dropped);
    check("drop_in_holdoff_state", 32'(bus_if.shaper_state), 32'd3);
    wait_idle(HOLDOFF_CYCLES + 10);
    check_counts("drops_busy");

    // Detector not ready: request dropped, FSM stays idle.
    bus_if.detector_ready = 1'b0;
    repeat (4) tick();
    pulse_req();
    exp_dropped = sat_inc(exp_dropped);
    repeat (3) tick();
    check("not_ready_state", 32'(bus_if.shaper_state), 32'd0);
    check_counts("not_ready");
    bus_if.detector_ready = 1'b1;
    repeat (3) tick();

    // Disarmed: request ignored entirely.
    bus_if.arm = 1'b0;
    pulse_req();
    repeat (3) tick();
    check("disarmed_state", 32'(bus_if.shaper_state), 32'd0);
    check_counts("disarmed");
    bus_if.arm = 1'b1;
    tick();

    // Asynchronous reset in the middle of a pulse.
    fire(5, k);
    wait_until(k + 6 + PULSE_CYCLES / 2);
    abort_pulse = 1'b1;
    #2;
    reset_signal = 1'b1;
    #1;
    exp_issued = 0;
    exp_dropped = 0;
    check("async_rst_trig", 32'(bus_if.trigger_out), 32'd0);
    check("async_rst_state", 32'(bus_if.shaper_state), 32'd0);
    check_counts("async_rst");
    repeat (2) tick();
    reset_signal = 1'b0;
    repeat (3) tick();
    abort_pulse = 1'b0;
    fire(7, k);
    wait_idle(PULSE_CYCLES + HOLDOFF_CYCLES + 20);
    exp_issued = sat_inc(exp_issued);
    check_counts("after_rst");

    // Drive the issued counter into saturation and one pulse beyond.
    for (int i = 0; i < CNT_MAX; i++) begin
      fire(2, k);
      wait_idle(PULSE_CYCLES + HOLDOFF_CYCLES + 20);
      exp_issued = sat_inc(exp_issued);
      check("sat_issued", 32'(bus_if.issued_count), 32'(exp_issued));
    end
    check("sat_value", 32'(bus_if.issued_count), 32'(CNT_MAX));

    // Plain clear, then a clear landing on the same edge as an increment.
    bus_if.clear_counts = 1'b1;
    tick();
    bus_if.clear_counts = 1'b0;
    exp_issued = 0;
    exp_dropped = 0;
    check_counts("clear");
    fire(3, k);
    wait_until(k + 4 + PULSE_CYCLES - 1);
    bus_if.clear_counts = 1'b1;
    tick();
    bus_if.clear_counts = 1'b0;
    check("clear_vs_inc_issued", 32'(bus_if.issued_count), 32'd0);
    check("clear_keeps_fsm", 32'(bus_if.shaper_state), 32'd3);
    wait_idle(HOLDOFF_CYCLES + 10);
    check_counts("final");
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
